// File: rtl/iic_pkg.sv
// Shared definitions for the I2C target receiver: FSM state encoding, SHT21 address, ACK levels.
package iic_pkg;

  typedef logic [2:0] iic_state_t;

  localparam iic_state_t ST_IDLE     = 3'd0;
  localparam iic_state_t ST_ADDR     = 3'd1;
  localparam iic_state_t ST_ADDR_ACK = 3'd2;
  localparam iic_state_t ST_DATA     = 3'd3;
  localparam iic_state_t ST_DATA_ACK = 3'd4;
  localparam iic_state_t ST_IGNORE   = 3'd5;

  localparam logic [6:0] SHT21_ADDR    = 7'h40;
  localparam logic       ACK_BIT       = 1'b0;
  localparam logic       NACK_BIT      = 1'b1;
  localparam logic       RW_WRITE      = 1'b0;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  // Only writes to our own address are accepted; reads are refused.
  function automatic logic addr_match(input logic [7:0] addr_rw, input logic [6:0] own);
    return (addr_rw[7:1] == own) && (addr_rw[0] == RW_WRITE);
  endfunction

endpackage

// File: rtl/iic_glitch_filt.sv
// Single-line glitch filter: the output takes a new level only after FILT_LEN
// consecutive samples of that level; shorter pulses are swallowed.
module iic_glitch_filt #(
  parameter int unsigned FILT_LEN = 4,
  parameter logic        RST_VAL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned      CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = din;
        cnt_d  = '0;
      end else begin
        dout_d = dout_q;
        cnt_d  = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= RST_VAL;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/iic_slave_rx.sv
// I2C target receiver: oversampled START/STOP detection, 7-bit address match, write-byte capture
// and ACK/NACK drive. Define IIC_SLAVE_GLITCH_FILT_EN to insert iic_glitch_filt on SCL and SDA.
module iic_slave_rx
  import iic_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = SHT21_ADDR,
  parameter int unsigned FILT_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       addressed
);

  logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic scl_f_s, sda_f_s;
  logic scl_hist_q, sda_hist_q;
  logic scl_rise_s, scl_fall_s, start_s, stop_s;
  logic byte_done_s, addr_ok_s;
  logic [7:0] shift_in_s;

  iic_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       addressed_q, addressed_d;
  logic       sda_oe_q, sda_oe_d;

  // An idle bus is high on both lines, so the sampling chain resets high to avoid false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILT_EN
  iic_glitch_filt #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_scl_filt (
    .clk  (clk),
    .rst  (rst),
    .din  (scl_s2_q),
    .dout (scl_f_s)
  );

  iic_glitch_filt #(.FILT_LEN(FILT_LEN), .RST_VAL(1'b1)) u_sda_filt (
    .clk  (clk),
    .rst  (rst),
    .din  (sda_s2_q),
    .dout (sda_f_s)
  );
`else
  assign scl_f_s = scl_s2_q;
  assign sda_f_s = sda_s2_q;

  // FILT_LEN only shapes the filter; nothing to build without it.
  if (FILT_LEN == 0) begin : g_filt_len_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_f_s;
      sda_hist_q <= sda_f_s;
    end
  end

  assign scl_rise_s  = scl_f_s & ~scl_hist_q;
  assign scl_fall_s  = ~scl_f_s & scl_hist_q;
  assign start_s     = scl_f_s & scl_hist_q & sda_hist_q & ~sda_f_s;
  assign stop_s      = scl_f_s & scl_hist_q & ~sda_hist_q & sda_f_s;
  assign byte_done_s = (bit_cnt_q == BITS_PER_BYTE);
  assign shift_in_s  = {shift_q[6:0], sda_f_s};
  assign addr_ok_s   = addr_match(shift_q, SLAVE_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus conditions outrank bit handling in every state.
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = ST_ADDR;
    end else if (stop_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_IDLE;
        ST_ADDR: begin
          if (scl_fall_s && byte_done_s) begin
            state_d = addr_ok_s ? ST_ADDR_ACK : ST_IGNORE;
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR_ACK: state_d = scl_fall_s ? ST_DATA : ST_ADDR_ACK;
        ST_DATA: begin
          if (scl_fall_s && byte_done_s) begin
            state_d = rx_ready ? ST_DATA_ACK : ST_IGNORE;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA_ACK: state_d = scl_fall_s ? ST_DATA : ST_DATA_ACK;
        ST_IGNORE:   state_d = ST_IGNORE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    start_det_d = start_s;
    stop_det_d  = stop_s;
    addressed_d = addressed_q;
    sda_oe_d    = sda_oe_q;
    if (start_s) begin
      bit_cnt_d   = 4'd0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_s) begin
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise_s && !byte_done_s) begin
            shift_d   = shift_in_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if ((state_q == ST_DATA) && (bit_cnt_q == BITS_PER_BYTE - 4'd1)) begin
              rx_data_d  = shift_in_s;
              rx_valid_d = 1'b1;
            end else begin
              rx_data_d  = rx_data_q;
              rx_valid_d = 1'b0;
            end
          end else if (scl_fall_s && byte_done_s) begin
            // Drive the ACK only once SCL is low so SDA never moves while SCL is high.
            sda_oe_d = (state_q == ST_ADDR) ? addr_ok_s : rx_ready;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 4'd0;
            addressed_d = 1'b1;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_IDLE, ST_IGNORE: sda_oe_d = 1'b0;
        default: begin
          sda_oe_d    = 1'b0;
          addressed_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      addressed_q <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      addressed_q <= addressed_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign sda       = sda_oe_q ? ACK_BIT : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign addressed = addressed_q;

endmodule

// File: tb/tb_iic_slave_rx.sv
// Self-checking bench for iic_slave_rx: table of write frames (hand-derived and randomized with a
// transaction-level model), plus repeated START, reset-during-ACK and (with the filter) glitch sequences.
module tb_iic_slave_rx;
  import iic_pkg::*;

  localparam logic [6:0] ADDR = 7'h40;
  localparam int Q = 120;
  localparam int NHAND = 9;
  localparam int NV = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic       rx_ready = 1'b1;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, start_det, stop_det, addressed;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  iic_slave_rx #(.SLAVE_ADDR(ADDR), .FILT_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .start_det (start_det),
    .stop_det  (stop_det),
    .addressed (addressed)
  );

  always #5 clk = ~clk;

  logic [7:0] got_q [$];
  int start_cnt = 0, stop_cnt = 0, drive_cycles = 0;

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (!m_sda_oe && sda === 1'b0) drive_cycles++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]      addr_byte;
    logic [1:0]      nbytes;
    logic [2:0][7:0] data;
    logic [2:0]      ready;
    logic            exp_addr_ack;
    logic [2:0]      exp_data_ack;
    logic [1:0]      exp_nvalid;
    logic [2:0][7:0] exp_rx;
    logic            exp_addressed;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [7:0] a, input logic [1:0] n, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] rdy);
    vec_t v = '0;
    v.addr_byte = a;
    v.nbytes    = n;
    v.data[0]   = d0;
    v.data[1]   = d1;
    v.data[2]   = d2;
    v.ready     = rdy;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t v, input logic aa, input logic [2:0] da,
                                    input logic [1:0] nv, input logic [7:0] r0, input logic [7:0] r1,
                                    input logic [7:0] r2, input logic ad);
    vec_t r = v;
    r.exp_addr_ack  = aa;
    r.exp_data_ack  = da;
    r.exp_nvalid    = nv;
    r.exp_rx[0]     = r0;
    r.exp_rx[1]     = r1;
    r.exp_rx[2]     = r2;
    r.exp_addressed = ad;
    return r;
  endfunction

  // Transaction-level reference: who gets ACKed and which bytes are delivered.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic listening;
    int   k = 0;
    r.exp_addr_ack  = (v.addr_byte[7:1] == ADDR) && (v.addr_byte[0] == 1'b0);
    r.exp_addressed = r.exp_addr_ack;
    r.exp_data_ack  = '0;
    r.exp_rx        = '0;
    listening       = r.exp_addr_ack;
    for (int i = 0; i < int'(v.nbytes); i++) begin
      if (listening) begin
        r.exp_rx[k]       = v.data[i];
        k++;
        r.exp_data_ack[i] = v.ready[i];
        listening         = v.ready[i];
      end
    end
    r.exp_nvalid = 2'(k);
    return r;
  endfunction

  task automatic bus_start();
    if (scl == 1'b0) begin
      #Q; m_sda_oe = 1'b0;
      #Q; scl = 1'b1;
    end
    #Q; m_sda_oe = 1'b1;
    #Q; scl = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      #Q; m_sda_oe = ~b[i];
      #Q; scl = 1'b1;
      #(2*Q); scl = 1'b0;
    end
  endtask

  // ACK counts only if SDA is low both mid-high and just before SCL falls.
  task automatic ack_bit(output logic ack);
    logic s1, s2;
    #Q; m_sda_oe = 1'b0;
    #Q; scl = 1'b1;
    #Q; s1 = sda;
    #(Q-10); s2 = sda;
    #10; scl = 1'b0;
    ack = (s1 === 1'b0) && (s2 === 1'b0);
  endtask

  task automatic bus_stop();
    #Q; m_sda_oe = 1'b1;
    #Q; scl = 1'b1;
    #Q; m_sda_oe = 1'b0;
    #(2*Q);
  endtask

  task automatic run_frame(input vec_t v);
    logic       ack;
    logic [2:0] acks;
    int base_s, base_p, base_g, base_d;
    base_s = start_cnt; base_p = stop_cnt; base_g = got_q.size(); base_d = drive_cycles;
    acks = 3'b000;
    bus_start();
    send_bits(v.addr_byte);
    ack_bit(ack);
    chk("addr_ack", {31'd0, ack}, {31'd0, v.exp_addr_ack});
    for (int i = 0; i < int'(v.nbytes); i++) begin
      rx_ready = v.ready[i];
      send_bits(v.data[i]);
      ack_bit(ack);
      acks[i] = ack;
    end
    #Q;
    chk("data_ack", {29'd0, acks}, {29'd0, v.exp_data_ack});
    chk("addressed", {31'd0, addressed}, {31'd0, v.exp_addressed});
    bus_stop();
    chk("n_valid", got_q.size() - base_g, {30'd0, v.exp_nvalid});
    for (int k = 0; k < int'(v.exp_nvalid) && (base_g + k) < got_q.size(); k++)
      chk("rx_byte", {24'd0, got_q[base_g + k]}, {24'd0, v.exp_rx[k]});
    if (v.exp_nvalid != 2'd0)
      chk("rx_data_hold", {24'd0, rx_data}, {24'd0, v.exp_rx[v.exp_nvalid - 2'd1]});
    chk("start_cnt", start_cnt - base_s, 32'd1);
    chk("stop_cnt", stop_cnt - base_p, 32'd1);
    chk("sda_driven", {31'd0, drive_cycles != base_d}, {31'd0, v.exp_addr_ack});
    chk("addressed_after_stop", {31'd0, addressed}, 32'd0);
  endtask

  initial begin
    logic ack;
    int base_s, base_p, base_g, base_d;
    logic [7:0] a;

    vecs[0] = with_exp(mk(8'h80, 2'd2, 8'hA5, 8'h3C, 8'h00, 3'b111), 1'b1, 3'b011, 2'd2, 8'hA5, 8'h3C, 8'h00, 1'b1);
    vecs[1] = with_exp(mk(8'h82, 2'd1, 8'h55, 8'h00, 8'h00, 3'b111), 1'b0, 3'b000, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[2] = with_exp(mk(8'h81, 2'd1, 8'h55, 8'h00, 8'h00, 3'b111), 1'b0, 3'b000, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[3] = with_exp(mk(8'h80, 2'd2, 8'h12, 8'h99, 8'h00, 3'b110), 1'b1, 3'b000, 2'd1, 8'h12, 8'h00, 8'h00, 1'b1);
    vecs[4] = with_exp(mk(8'h00, 2'd1, 8'hAA, 8'h00, 8'h00, 3'b111), 1'b0, 3'b000, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[5] = with_exp(mk(8'h80, 2'd3, 8'h00, 8'hFF, 8'h01, 3'b111), 1'b1, 3'b111, 2'd3, 8'h00, 8'hFF, 8'h01, 1'b1);
    vecs[6] = with_exp(mk(8'hFE, 2'd1, 8'h33, 8'h00, 8'h00, 3'b111), 1'b0, 3'b000, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[7] = with_exp(mk(8'h80, 2'd0, 8'h00, 8'h00, 8'h00, 3'b111), 1'b1, 3'b000, 2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    vecs[8] = with_exp(mk(8'h80, 2'd3, 8'hDE, 8'hAD, 8'hBE, 3'b101), 1'b1, 3'b001, 2'd2, 8'hDE, 8'hAD, 8'h00, 1'b1);
    for (int t = NHAND; t < NV; t++) begin
      a = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'($urandom);
      vecs[t] = model(mk(a, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
                         {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)}));
    end

    #100;
    chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_start_det", {31'd0, start_det}, 32'd0);
    chk("rst_stop_det", {31'd0, stop_det}, 32'd0);
    chk("rst_addressed", {31'd0, addressed}, 32'd0);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    rst = 1'b0;
    #(4*Q);

    for (int t = 0; t < NV; t++) run_frame(vecs[t]);

    // Repeated START after the first data byte, then a fresh write.
    base_s = start_cnt; base_p = stop_cnt; base_g = got_q.size();
    rx_ready = 1'b1;
    bus_start();
    send_bits(8'h80); ack_bit(ack);
    chk("rs_addr_ack1", {31'd0, ack}, 32'd1);
    send_bits(8'h11); ack_bit(ack);
    chk("rs_data_ack1", {31'd0, ack}, 32'd1);
    #Q;
    chk("rs_addressed_high", {31'd0, addressed}, 32'd1);
    bus_start();
    chk("rs_addressed_drop", {31'd0, addressed}, 32'd0);
    send_bits(8'h80); ack_bit(ack);
    chk("rs_addr_ack2", {31'd0, ack}, 32'd1);
    #Q;
    chk("rs_addressed_rise", {31'd0, addressed}, 32'd1);
    send_bits(8'h77); ack_bit(ack);
    chk("rs_data_ack2", {31'd0, ack}, 32'd1);
    bus_stop();
    chk("rs_start_cnt", start_cnt - base_s, 32'd2);
    chk("rs_stop_cnt", stop_cnt - base_p, 32'd1);
    chk("rs_n_valid", got_q.size() - base_g, 32'd2);
    if (got_q.size() >= base_g + 2) begin
      chk("rs_byte0", {24'd0, got_q[base_g]}, 32'h11);
      chk("rs_byte1", {24'd0, got_q[base_g + 1]}, 32'h77);
    end
    chk("rs_rx_data", {24'd0, rx_data}, 32'h77);

    // Reset while the data ACK is being driven on bit 9.
    bus_start();
    send_bits(8'h80); ack_bit(ack);
    send_bits(8'hA5);
    #Q; m_sda_oe = 1'b0;
    #Q; scl = 1'b1;
    #Q;
    chk("rst_mid_ack_driven", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_sda_released", {31'd0, sda}, 32'd1);
    #(Q-1);
    chk("rst_mid_rx_data", {24'd0, rx_data}, 32'h00);
    chk("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_mid_addressed", {31'd0, addressed}, 32'd0);
    chk("rst_mid_start_det", {31'd0, start_det}, 32'd0);
    chk("rst_mid_stop_det", {31'd0, stop_det}, 32'd0);
    rst = 1'b0;
    #Q; scl = 1'b0;
    base_g = got_q.size(); base_d = drive_cycles;
    rx_ready = 1'b1;
    send_bits(8'h3C); ack_bit(ack);
    chk("post_rst_ack", {31'd0, ack}, 32'd0);
    chk("post_rst_no_rx", got_q.size() - base_g, 32'd0);
    chk("post_rst_no_drive", drive_cycles - base_d, 32'd0);
    chk("post_rst_addressed", {31'd0, addressed}, 32'd0);
    bus_stop();

`ifdef IIC_SLAVE_GLITCH_FILT_EN
    // Two-clock SCL pulses while SCL is low must not shift a bit.
    base_g = got_q.size();
    bus_start();
    #Q; scl = 1'b1; #20; scl = 1'b0;
    send_bits(8'h80); ack_bit(ack);
    chk("glitch_addr_ack", {31'd0, ack}, 32'd1);
    #Q; scl = 1'b1; #20; scl = 1'b0;
    send_bits(8'hC3); ack_bit(ack);
    chk("glitch_data_ack", {31'd0, ack}, 32'd1);
    bus_stop();
    chk("glitch_n_valid", got_q.size() - base_g, 32'd1);
    if (got_q.size() > base_g) chk("glitch_byte", {24'd0, got_q[base_g]}, 32'hC3);
`endif

    run_frame(model(mk(8'h80, 2'd1, 8'h5A, 8'h00, 8'h00, 3'b111)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave_rx.md
# iic_slave_rx

I2C target-side (responder) receiver for the SHT21 sensor link, sitting at the far end of the bus driven by the iic master controller. It oversamples SCL/SDA on the 100 MHz system clock, detects START/STOP conditions, matches the 7-bit address, shifts in write bytes and drives ACK/NACK on SDA. It lets the master-side controller be looped back and verified in-system without a physical sensor.

## Interface
Parameters:
- SLAVE_ADDR, 7'h40, 7-bit target address (SHT21 default).
- FILT_LEN, 4, glitch-filter stability length in clk cycles; used only with the filter macro.

Ports:
- clk  input  1  100 MHz system clock; one clock domain.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock from the master (asynchronous to clk).
- sda  inout  1  bus data; block drives only 1'b0 (ACK) or 1'bz.
- rx_ready  input  1  sampled at ACK decision; 1 = accept byte (ACK), 0 = NACK.
- rx_data  output  8  last received data byte, MSB first on the bus.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- start_det  output  1  one-clk pulse on START or repeated START.
- stop_det  output  1  one-clk pulse on STOP.
- addressed  output  1  high from address ACK until STOP/START.

## Operation
- Input path: scl and sda each pass a 2-flop synchronizer, then a 1-flop history register for edge detection.
- START: sync SDA falls while sync SCL high. STOP: sync SDA rises while sync SCL high. Both are checked in every state and take priority over bit handling.
- Bits are sampled on SCL rising edge; SDA drive changes only on SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: wait for START -> ADDR, bit counter = 0.
  - ADDR: shift 8 bits (7 address + R/W). On 8th falling edge: if addr == SLAVE_ADDR and R/W == 0, drive SDA low -> ADDR_ACK; else release -> IGNORE.
  - ADDR_ACK: on 9th falling edge release SDA, set addressed -> DATA.
  - DATA: shift 8 bits; on 8th rising edge load rx_data, pulse rx_valid. On 8th falling edge: rx_ready = 1 -> drive low, DATA_ACK; rx_ready = 0 -> release, IGNORE.
  - DATA_ACK: on 9th falling edge release SDA -> DATA, counter = 0.
  - IGNORE: SDA released; wait for START or STOP.
- START in any state -> ADDR, counter cleared, SDA released, addressed cleared (repeated START supported). STOP in any state -> IDLE, SDA released, addressed cleared.
- R/W = 1 (read) is not supported: NACKed, -> IGNORE.
- Bit counter is 4 bits, saturating-free: cleared on START and at each ACK release; never exceeds 8 in shift states.

## Timing
- Reset values: rx_data = 8'h00, rx_valid = 0, start_det = 0, stop_det = 0, addressed = 0, SDA released (z), state IDLE.
- Detection latency (no filter): 3 clk from pin edge to internal edge event; start_det/stop_det/rx_valid asserted the cycle after that event.
- SDA drive asserted/released 1 clk after the detected SCL falling edge; must hold through full SCL high of bit 9.
- rx_valid is exactly one clk; consumer must capture rx_data before the next byte's 8th rising edge.
- Reset mid-transfer releases SDA immediately (asynchronous), returns to IDLE; bus activity before the next START is ignored.

## Configuration
- IIC_SLAVE_GLITCH_FILT_EN defined: after synchronization each line passes a filter that updates its output only after FILT_LEN consecutive equal samples; adds FILT_LEN clk to all latencies; suppresses pulses shorter than FILT_LEN clk.
- Undefined: filter absent, synchronizer output used directly; FILT_LEN unused.

## Structure
- Shared package iic_pkg: FSM state encoding (3-bit localparams for the six states), default SHT21 address 7'h40, ACK/NACK constants.
- One sub-module: iic_glitch_filt (single-line, parameter FILT_LEN), instantiated twice, only under the macro.

## Test plan
- Write 0x40+W, data 0xA5, 0x3C, STOP with rx_ready = 1 -> ACK on bits 9; rx_valid twice with rx_data 0xA5 then 0x3C; one start_det, one stop_det.
- Address 0x41+W -> SDA never driven, state IGNORE, no rx_valid, addressed stays 0.
- Address 0x40+R -> NACK, no SDA drive, IGNORE until STOP.
- 0x40+W, data 0x12 with rx_ready = 0 -> rx_valid with 0x12, NACK on bit 9, subsequent byte ignored.
- Repeated START after first data byte, then 0x40+W, 0x77 -> two start_det pulses, addressed drops then rises, rx_data 0x77.
- Assert rst during bit 9 ACK drive -> SDA released same cycle, all outputs at reset values; with macro, 2-clk SCL glitch produces no bit shift.
